// File: rtl/vecmat_pkg.sv
// Shared constants and FSM encoding for the vecmat operand loader.
// Optional zero-pad feature is controlled by VECMAT_LOADER_ZEROPAD_EN.
package vecmat_pkg;

    localparam int ELEM_W     = 16;
    localparam int VECT_DEPTH = 64;
    localparam int ARRAYSIZE  = ELEM_W * VECT_DEPTH;
    localparam int CNT_W      = $clog2(VECT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_Q,
        LOAD_K,
        EMIT
    } loader_state_t;

endpackage

// File: rtl/vecmat_row_assembler.sv
// Staging register that packs a serial element stream into one ARRAYSIZE-wide row.
// VECMAT_LOADER_ZEROPAD_EN adds the 'last' input for early row completion.
module vecmat_row_assembler
    import vecmat_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [ELEM_W-1:0]    data,
`ifdef VECMAT_LOADER_ZEROPAD_EN
    input  logic                 last,
`endif
    output logic [ARRAYSIZE-1:0] row_data,
    output logic                 full
);

    logic [ARRAYSIZE-1:0] staging_q, staging_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 early_end;

    // row_data already contains the element accepted this cycle, so the
    // completing element is visible to the parent in the same cycle.
    for (genvar gi = 0; gi < VECT_DEPTH; gi++) begin : g_slot
        assign row_data[gi*ELEM_W +: ELEM_W] =
            (accept && (cnt_q == CNT_W'(gi))) ? data : staging_q[gi*ELEM_W +: ELEM_W];
    end

`ifdef VECMAT_LOADER_ZEROPAD_EN
    assign early_end = last;
`else
    assign early_end = 1'b0;
`endif

    assign full = accept && ((cnt_q == CNT_W'(VECT_DEPTH - 1)) || early_end);

    always_comb begin
        staging_d = row_data;
        cnt_d     = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Clearing on completion is what makes early-ended rows zero padded.
        if (clear || full) begin
            staging_d = '0;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            staging_q <= '0;
            cnt_q     <= '0;
        end else begin
            staging_q <= staging_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/vecmat_operand_loader.sv
// Assembles one Q vector then NUM_ROWS K rows and strobes each pair to the dot-product unit.
// Define VECMAT_LOADER_ZEROPAD_EN to add the in_last early-end port.
module vecmat_operand_loader
    import vecmat_pkg::*;
#(
    parameter  int NUM_ROWS = 64,
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ELEM_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
`ifdef VECMAT_LOADER_ZEROPAD_EN
    input  logic                 in_last,
`endif
    output logic [ARRAYSIZE-1:0] vector,
    output logic [ARRAYSIZE-1:0] matrix,
    output logic                 out_valid,
    output logic [ROW_W-1:0]     row_idx,
    output logic                 busy,
    output logic                 done
);

    loader_state_t        state_q, state_d;
    logic [ARRAYSIZE-1:0] vector_q, vector_d;
    logic [ARRAYSIZE-1:0] matrix_q, matrix_d;
    logic [ROW_W-1:0]     row_q, row_d;

    logic [ARRAYSIZE-1:0] row_data;
    logic                 row_full;
    logic                 accept;
    logic                 last_row;
    logic                 asm_clear;

    assign accept    = in_valid && in_ready;
    assign last_row  = (row_q == ROW_W'(NUM_ROWS - 1));
    assign asm_clear = (state_q == IDLE);

    vecmat_row_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (asm_clear),
        .accept   (accept),
        .data     (in_data),
`ifdef VECMAT_LOADER_ZEROPAD_EN
        .last     (in_last),
`endif
        .row_data (row_data),
        .full     (row_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            vector_q <= '0;
            matrix_q <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            vector_q <= vector_d;
            matrix_q <= matrix_d;
            row_q    <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = LOAD_Q;
            LOAD_Q:  if (row_full) state_d = LOAD_K;
            LOAD_K:  if (row_full) state_d = EMIT;
            EMIT:    state_d = last_row ? IDLE : LOAD_K;
            default: state_d = IDLE;
        endcase
    end

    // vector only updates when a Q completes, so it survives all K rows.
    always_comb begin
        vector_d = vector_q;
        matrix_d = matrix_q;
        row_d    = row_q;
        if ((state_q == LOAD_Q) && row_full) begin
            vector_d = row_data;
        end
        if ((state_q == LOAD_K) && row_full) begin
            matrix_d = row_data;
        end
        if ((state_q == IDLE) && start) begin
            row_d = '0;
        end
        if (state_q == EMIT) begin
            row_d = last_row ? '0 : row_q + 1'b1;
        end
    end

    always_comb begin
        in_ready  = (state_q == LOAD_Q) || (state_q == LOAD_K);
        out_valid = (state_q == EMIT);
        done      = (state_q == EMIT) && last_row;
        busy      = (state_q != IDLE);
        vector    = vector_q;
        matrix    = matrix_q;
        row_idx   = row_q;
    end

endmodule

// File: tb/tb_vecmat_operand_loader.sv
// Directed bench for vecmat_operand_loader with NUM_ROWS=2.
// Zero-pad scenario runs only when VECMAT_LOADER_ZEROPAD_EN is defined.
module tb_vecmat_operand_loader;
    import vecmat_pkg::*;

    localparam int NROWS = 2;
    localparam int RW    = 1;
    localparam int NSNAP = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [ELEM_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
`ifdef VECMAT_LOADER_ZEROPAD_EN
    logic                 in_last;
`endif
    logic [ARRAYSIZE-1:0] vector;
    logic [ARRAYSIZE-1:0] matrix;
    logic                 out_valid;
    logic [RW-1:0]        row_idx;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    vecmat_operand_loader #(.NUM_ROWS(NROWS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef VECMAT_LOADER_ZEROPAD_EN
        .in_last   (in_last),
`endif
        .vector    (vector),
        .matrix    (matrix),
        .out_valid (out_valid),
        .row_idx   (row_idx),
        .busy      (busy),
        .done      (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitor, sampled on the falling edge
    int                   cyc = 0;
    int                   strobe_cnt = 0;
    logic [ARRAYSIZE-1:0] snap_vec [NSNAP];
    logic [ARRAYSIZE-1:0] snap_mat [NSNAP];
    int                   snap_row [NSNAP];
    int                   snap_done[NSNAP];
    int                   snap_rdy [NSNAP];
    int                   snap_cyc [NSNAP];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid) begin
            if (strobe_cnt < NSNAP) begin
                snap_vec[strobe_cnt]  <= vector;
                snap_mat[strobe_cnt]  <= matrix;
                snap_row[strobe_cnt]  <= int'(row_idx);
                snap_done[strobe_cnt] <= int'(done);
                snap_rdy[strobe_cnt]  <= int'(in_ready);
                snap_cyc[strobe_cnt]  <= cyc;
            end
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    // Element stream under test
    logic [ELEM_W-1:0] stream_data[256];
`ifdef VECMAT_LOADER_ZEROPAD_EN
    logic              stream_last[256];
`endif
    int                stream_len;

    typedef struct {
        string             name;
        int                sel;   // 0: vector @strobe0, 1: matrix @strobe0, 2: matrix @strobe1
        int                idx;
        logic [ELEM_W-1:0] exp;
    } probe_t;
    probe_t probes[8];

    task automatic check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [ARRAYSIZE-1:0] act,
                           input logic [ARRAYSIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [ARRAYSIZE-1:0] mk_row(input int base);
        logic [ARRAYSIZE-1:0] r;
        for (int i = 0; i < VECT_DEPTH; i++) r[i*ELEM_W +: ELEM_W] = ELEM_W'(base + i);
        return r;
    endfunction

    function automatic logic [ARRAYSIZE-1:0] mk_zp_row();
        logic [ARRAYSIZE-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[i*ELEM_W +: ELEM_W] = ELEM_W'(16'h0100 + i);
        r[9*ELEM_W +: ELEM_W] = 16'h0AAA;
        return r;
    endfunction

    task automatic build_stream(input bit zp);
        int n = 0;
        for (int i = 0; i < VECT_DEPTH; i++) begin
            stream_data[n] = ELEM_W'(i + 1);
`ifdef VECMAT_LOADER_ZEROPAD_EN
            stream_last[n] = 1'b0;
`endif
            n++;
        end
        for (int i = 0; i < (zp ? 10 : VECT_DEPTH); i++) begin
            stream_data[n] = (zp && i == 9) ? 16'h0AAA : ELEM_W'(16'h0100 + i);
`ifdef VECMAT_LOADER_ZEROPAD_EN
            stream_last[n] = (zp && i == 9);
`endif
            n++;
        end
        for (int i = 0; i < VECT_DEPTH; i++) begin
            stream_data[n] = ELEM_W'(16'h0200 + i);
`ifdef VECMAT_LOADER_ZEROPAD_EN
            stream_last[n] = 1'b0;
`endif
            n++;
        end
        stream_len = n;
    endtask

    // start together with a valid element: that element must not be taken
    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        @(posedge clk);
    endtask

    task automatic feed(input bit gaps, input int abort_at, input int spulse_at);
        int idx   = 0;
        int guard = 0;
        bit acc;
        while (idx < stream_len && idx != abort_at && guard < 3000) begin
            @(negedge clk);
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stream_data[idx];
`ifdef VECMAT_LOADER_ZEROPAD_EN
            in_last  = stream_last[idx];
`endif
            start    = (idx == spulse_at);
            #1;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
`ifdef VECMAT_LOADER_ZEROPAD_EN
        in_last  = 1'b0;
`endif
        check_i("feed_progress", idx, (abort_at < 0) ? stream_len : abort_at);
    endtask

    task automatic wait_idle();
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (busy && g < 200);
        check_i("wait_idle_busy", int'(busy), 0);
    endtask

    task automatic check_run(input string nm, input int base, input bit zp, input bit timed);
        check_i({nm, "_strobes"}, strobe_cnt - base, NROWS);
        check_w({nm, "_vec0"}, snap_vec[base], mk_row(1));
        check_w({nm, "_vec1"}, snap_vec[base+1], mk_row(1));
        check_w({nm, "_mat0"}, snap_mat[base], zp ? mk_zp_row() : mk_row(16'h0100));
        check_w({nm, "_mat1"}, snap_mat[base+1], mk_row(16'h0200));
        check_i({nm, "_row0"}, snap_row[base], 0);
        check_i({nm, "_row1"}, snap_row[base+1], 1);
        check_i({nm, "_done0"}, snap_done[base], 0);
        check_i({nm, "_done1"}, snap_done[base+1], 1);
        check_i({nm, "_rdy_emit0"}, snap_rdy[base], 0);
        check_i({nm, "_rdy_emit1"}, snap_rdy[base+1], 0);
        if (timed) check_i({nm, "_cadence"}, snap_cyc[base+1] - snap_cyc[base], VECT_DEPTH + 1);
    endtask

    task automatic check_reset_outputs(input string nm);
        check_w({nm, "_vector"}, vector, '0);
        check_w({nm, "_matrix"}, matrix, '0);
        check_i({nm, "_out_valid"}, int'(out_valid), 0);
        check_i({nm, "_done"}, int'(done), 0);
        check_i({nm, "_busy"}, int'(busy), 0);
        check_i({nm, "_in_ready"}, int'(in_ready), 0);
        check_i({nm, "_row_idx"}, int'(row_idx), 0);
    endtask

    initial begin
        int base;
        int b1;
        logic [ELEM_W-1:0] w;

        probes[0] = '{"q_elem0",   0, 0,  16'h0001};
        probes[1] = '{"q_elem31",  0, 31, 16'h0020};
        probes[2] = '{"q_elem63",  0, 63, 16'h0040};
        probes[3] = '{"k0_elem0",  1, 0,  16'h0100};
        probes[4] = '{"k0_elem9",  1, 9,  16'h0109};
        probes[5] = '{"k0_elem63", 1, 63, 16'h013F};
        probes[6] = '{"k1_elem0",  2, 0,  16'h0200};
        probes[7] = '{"k1_elem63", 2, 63, 16'h023F};

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef VECMAT_LOADER_ZEROPAD_EN
        in_last  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Continuous stream, element offered during EMIT must be held
        build_stream(1'b0);
        base = strobe_cnt;
        do_start();
        feed(1'b0, -1, -1);
        wait_idle();
        check_run("t1", base, 1'b0, 1'b1);
        b1 = base;
        for (int p = 0; p < 8; p++) begin
            case (probes[p].sel)
                0:       w = snap_vec[b1][probes[p].idx*ELEM_W +: ELEM_W];
                1:       w = snap_mat[b1][probes[p].idx*ELEM_W +: ELEM_W];
                default: w = snap_mat[b1+1][probes[p].idx*ELEM_W +: ELEM_W];
            endcase
            check_i({"probe_", probes[p].name}, int'(w), int'(probes[p].exp));
        end

        // Random valid gaps
        base = strobe_cnt;
        do_start();
        feed(1'b1, -1, -1);
        wait_idle();
        check_run("t2", base, 1'b0, 1'b0);

        // Reset after 30 K0 elements, then a fresh run
        base = strobe_cnt;
        do_start();
        feed(1'b0, VECT_DEPTH + 30, -1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        @(negedge clk);
        check_i("midrst_no_strobe", strobe_cnt - base, 0);
        base = strobe_cnt;
        do_start();
        feed(1'b0, -1, -1);
        wait_idle();
        check_run("t4", base, 1'b0, 1'b1);

        // start pulsed during LOAD_K
        base = strobe_cnt;
        do_start();
        feed(1'b0, -1, VECT_DEPTH + 36);
        wait_idle();
        check_run("t5", base, 1'b0, 1'b1);

`ifdef VECMAT_LOADER_ZEROPAD_EN
        build_stream(1'b1);
        base = strobe_cnt;
        do_start();
        feed(1'b0, -1, -1);
        wait_idle();
        check_run("t6", base, 1'b1, 1'b0);
        check_i("t6_elem9", int'(snap_mat[base][159:144]), 16'h0AAA);
        check_i("t6_pad_zero", int'(snap_mat[base][1023:160] == '0), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
